// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the hazard/forwarding controller:
//     FWD_RF / FWD_WB / FWD_MEM : ALU operand forward-select encodings
//     reg_addr_w()              : register-address width for a register count
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from writeback stage
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from memory stage

    function automatic int reg_addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// ----------------------------------------------------------------------------
// mdu_scoreboard
//   Tracks the multi-cycle multiply/divide unit: occupancy counter, the
//   destination register of the operation in flight and a pending-write
//   bit per architectural register.
//
//   Ports
//     clk, rst     : clock, asynchronous active-high reset
//     mdu_start_i  : MDU operation presented in E
//     mdu_dst_i    : destination register of that operation
//     mem_stall_i  : data memory wait state (blocks acceptance)
//     mdu_busy_o   : occupancy counter non-zero
//     mdu_done_o   : result write strobe (counter == 1)
//     pend_o       : per-register pending-write bits, bit 0 always 0
// ----------------------------------------------------------------------------
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREGS   = 32,
    parameter  int MDU_LAT = 4,
    localparam int RW      = reg_addr_w(NREGS),
    localparam int CW      = $clog2(MDU_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdu_start_i,
    input  logic [RW-1:0]    mdu_dst_i,
    input  logic             mem_stall_i,
    output logic             mdu_busy_o,
    output logic             mdu_done_o,
    output logic [NREGS-1:0] pend_o
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    dst_q, dst_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic             accept;

    assign mdu_busy_o = (cnt_q != '0);
    assign mdu_done_o = (cnt_q == CNT_ONE);
    assign pend_o     = pend_q;

    // A new op may start in the done cycle: the unit frees up on that edge.
    assign accept = mdu_start_i & ~mem_stall_i & (cnt_q <= CNT_ONE);

    always_comb begin
        cnt_d  = cnt_q;
        dst_d  = dst_q;
        pend_d = pend_q;
        if (accept) begin
            cnt_d = CNT_LOAD;
            dst_d = mdu_dst_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        // Clear first, then set, so a same-register restart stays pending.
        if (mdu_done_o) begin
            pend_d[dst_q] = 1'b0;
        end
        if (accept && (mdu_dst_i != '0)) begin
            pend_d[mdu_dst_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dst_q  <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dst_q  <= dst_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// ----------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard and forwarding controller for a 5-stage pipeline with a
//   multi-cycle MDU and a wait-stated data memory.
//
//   Ports
//     clk, rst                      : clock, asynchronous active-high reset
//     rsD/rtD/rsE/rtE               : source registers in D and E
//     WriteRegE/M/W, RegWriteE/M/W  : destination and its valid per stage
//     MemtoRegE/M                   : load in stage
//     BranchD                       : branch compare in D
//     MemAccessM, MemReadyM         : memory access in M, memory ready
//     MduStartE, MduDstE            : MDU op in E and its destination
//     ForwardAE/BE                  : ALU operand select (RF / WB / MEM)
//     ForwardAD/BD                  : forward M result to branch comparator
//     StallF/D/E/M                  : hold pipeline register feeding stage
//     FlushE/M/W                    : insert bubble into stage
//     MduBusy, MduDone              : MDU occupied, MDU result write strobe
//     StallCount                    : saturating count of StallF cycles
//
//   Handshake: MduStartE is a request that is taken on a rising edge only
//   when the MDU is free or finishing (counter <= 1) and memory is not in a
//   wait state; otherwise the E stage is held until that becomes true.
// ----------------------------------------------------------------------------
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter  int NREGS   = 32,
    parameter  int MDU_LAT = 4,
    parameter  int CNT_W   = 16,
    localparam int RW      = reg_addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RW-1:0]    rsD,
    input  logic [RW-1:0]    rtD,
    input  logic [RW-1:0]    rsE,
    input  logic [RW-1:0]    rtE,
    input  logic [RW-1:0]    WriteRegE,
    input  logic [RW-1:0]    WriteRegM,
    input  logic [RW-1:0]    WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    input  logic             MduStartE,
    input  logic [RW-1:0]    MduDstE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MduBusy,
    output logic             MduDone,
    output logic [CNT_W-1:0] StallCount
);

    logic [NREGS-1:0] pend;
    logic             memstall, mdustruct, lwstall, branchstall, mduhaz;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mdu_scoreboard #(
        .NREGS   (NREGS),
        .MDU_LAT (MDU_LAT)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .mdu_start_i (MduStartE),
        .mdu_dst_i   (MduDstE),
        .mem_stall_i (memstall),
        .mdu_busy_o  (MduBusy),
        .mdu_done_o  (MduDone),
        .pend_o      (pend)
    );

    // ---------------- forwarding ----------------
    always_comb begin
        ForwardAE = FWD_RF;
        if ((rsE != '0) && RegWriteM && (WriteRegM == rsE)) begin
            ForwardAE = FWD_MEM;
        end else if ((rsE != '0) && RegWriteW && (WriteRegW == rsE)) begin
            ForwardAE = FWD_WB;
        end
        ForwardBE = FWD_RF;
        if ((rtE != '0) && RegWriteM && (WriteRegM == rtE)) begin
            ForwardBE = FWD_MEM;
        end else if ((rtE != '0) && RegWriteW && (WriteRegW == rtE)) begin
            ForwardBE = FWD_WB;
        end
    end

    assign ForwardAD = (rsD != '0) & RegWriteM & (WriteRegM == rsD);
    assign ForwardBD = (rtD != '0) & RegWriteM & (WriteRegM == rtD);

    // ---------------- hazard terms ----------------
    assign memstall  = MemAccessM & ~MemReadyM;
    // Busy and not in the done cycle is exactly "counter > 1".
    assign mdustruct = MduStartE & MduBusy & ~MduDone;
    assign lwstall   = MemtoRegE & (rtE != '0) & ((rsD == rtE) | (rtD == rtE));
    assign branchstall = BranchD &
        ((RegWriteE & (WriteRegE != '0) & ((WriteRegE == rsD) | (WriteRegE == rtD))) |
         (MemtoRegM & ((WriteRegM == rsD) | (WriteRegM == rtD))));
    assign mduhaz    = pend[rsD] | pend[rtD];

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mdustruct) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (lwstall | branchstall | mduhaz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ---------------- stall-cycle counter ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

    localparam int NREGS   = 32;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, MduDstE;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    logic       MemAccessM, MemReadyM, MduStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM;
    logic       FlushE, FlushM, FlushW, MduBusy, MduDone;
    logic [CNT_W-1:0] StallCount;

    hazard_unit_mc #(.NREGS(NREGS), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .MduStartE(MduStartE), .MduDstE(MduDstE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .MduBusy(MduBusy), .MduDone(MduDone), .StallCount(StallCount)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-based view: an op accepted in cycle a occupies cycles a+1..a+LAT,
    // finishes in a+LAT, and its register is pending over the same window.
    int cyc = 0;
    int acc_cyc = -1000;
    int pend_from[NREGS];
    int pend_to[NREGS];
    int m_cnt = 0;

    task automatic model_clear();
        acc_cyc = -1000;
        m_cnt   = 0;
        for (int r = 0; r < NREGS; r++) begin
            pend_from[r] = 1;
            pend_to[r]   = 0;
        end
    endtask

    initial model_clear();

    function automatic bit m_busy();     return (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + MDU_LAT); endfunction
    function automatic bit m_done();     return cyc == acc_cyc + MDU_LAT; endfunction
    function automatic bit m_occupied(); return (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + MDU_LAT - 1); endfunction
    function automatic bit m_pend(input logic [4:0] r);
        return (r != 0) && (cyc >= pend_from[r]) && (cyc <= pend_to[r]);
    endfunction
    function automatic bit m_memstall(); return MemAccessM && !MemReadyM; endfunction
    function automatic bit m_struct();   return MduStartE && m_occupied(); endfunction
    function automatic bit m_hold();
        bit lw, br;
        lw = MemtoRegE && (rtE != 0) && (rsD == rtE || rtD == rtE);
        br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == rsD || WriteRegE == rtD)) ||
                         (MemtoRegM && (WriteRegM == rsD || WriteRegM == rtD)));
        return lw || br || m_pend(rsD) || m_pend(rtD);
    endfunction
    // 3 = memory wait, 2 = MDU structural, 1 = dependency, 0 = none
    function automatic int m_level();
        if (m_memstall()) return 3;
        if (m_struct())   return 2;
        if (m_hold())     return 1;
        return 0;
    endfunction
    function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (RegWriteM && WriteRegM == src) return 2'b10;
        if (RegWriteW && WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction
    function automatic bit m_fwd_d(input logic [4:0] src);
        return (src != 0) && RegWriteM && (WriteRegM == src);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear();
        end else begin
            if (MduStartE && !m_memstall() && !m_occupied()) begin
                acc_cyc = cyc;
                if (MduDstE != 0) begin
                    pend_from[MduDstE] = cyc + 1;
                    pend_to[MduDstE]   = cyc + MDU_LAT;
                end
            end
            if (m_level() != 0 && m_cnt < CNT_MAX) m_cnt++;
            cyc++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int lvl;
        lvl = m_level();
        check("ForwardAE", 32'(ForwardAE), 32'(m_fwd_e(rsE)));
        check("ForwardBE", 32'(ForwardBE), 32'(m_fwd_e(rtE)));
        check("ForwardAD", 32'(ForwardAD), 32'(m_fwd_d(rsD)));
        check("ForwardBD", 32'(ForwardBD), 32'(m_fwd_d(rtD)));
        check("StallF", 32'(StallF), 32'(lvl != 0));
        check("StallD", 32'(StallD), 32'(lvl != 0));
        check("StallE", 32'(StallE), 32'(lvl >= 2));
        check("StallM", 32'(StallM), 32'(lvl == 3));
        check("FlushE", 32'(FlushE), 32'(lvl == 1));
        check("FlushM", 32'(FlushM), 32'(lvl == 2));
        check("FlushW", 32'(FlushW), 32'(lvl == 3));
        check("MduBusy", 32'(MduBusy), 32'(m_busy()));
        check("MduDone", 32'(MduDone), 32'(m_done()));
        check("StallCount", 32'(StallCount), 32'(m_cnt));
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0; MduDstE = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MemAccessM = 0; MemReadyM = 1; MduStartE = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        repeat (2) next_cycle();
        settle();
        check("rst_MduBusy", 32'(MduBusy), 32'd0);
        check("rst_MduDone", 32'(MduDone), 32'd0);
        check("rst_StallCount", 32'(StallCount), 32'd0);
        next_cycle();
        rst = 1'b0;

        // forwarding
        next_cycle(); idle();
        rsE = 2; WriteRegM = 2; RegWriteM = 1; settle();
        check("fwd_M", 32'(ForwardAE), 32'h2);
        next_cycle();
        RegWriteM = 0; WriteRegW = 2; RegWriteW = 1; settle();
        check("fwd_W", 32'(ForwardAE), 32'h1);
        next_cycle();
        RegWriteM = 1; rtE = 2; settle();
        check("fwd_M_over_W", 32'(ForwardBE), 32'h2);
        next_cycle();
        rsE = 0; settle();
        check("fwd_r0", 32'(ForwardAE), 32'h0);
        next_cycle(); idle();
        rsD = 4; WriteRegM = 4; RegWriteM = 1; settle();
        check("fwd_D", 32'(ForwardAD), 32'h1);

        // load-use (StallCount -> 1)
        next_cycle(); idle();
        MemtoRegE = 1; rtE = 3; rtD = 3; settle();
        check("lw_StallF", 32'(StallF), 32'h1);
        check("lw_FlushE", 32'(FlushE), 32'h1);
        next_cycle();
        rtE = 0; settle();
        check("lw_r0", 32'(StallD), 32'h0);

        // branch compare against E destination (StallCount -> 2)
        next_cycle(); idle();
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; rsD = 5; settle();
        check("br_StallD", 32'(StallD), 32'h1);

        // MDU: accept in cycle 0
        next_cycle(); idle();
        MduStartE = 1; MduDstE = 7; settle();
        check("mdu0_StallF", 32'(StallF), 32'h0);
        next_cycle(); idle();
        rsD = 7; settle();                                   // cycle 1
        check("mdu1_StallD", 32'(StallD), 32'h1);
        check("mdu1_Busy", 32'(MduBusy), 32'h1);
        next_cycle();
        MduStartE = 1; MduDstE = 9; settle();                // cycle 2
        check("mdu2_StallE", 32'(StallE), 32'h1);
        check("mdu2_FlushM", 32'(FlushM), 32'h1);
        next_cycle();
        MduStartE = 0; settle();                             // cycle 3
        check("mdu3_StallD", 32'(StallD), 32'h1);
        next_cycle();
        MduStartE = 1; MduDstE = 9; settle();                // cycle 4
        check("mdu4_Done", 32'(MduDone), 32'h1);
        check("mdu4_StallE", 32'(StallE), 32'h0);
        check("mdu4_StallD", 32'(StallD), 32'h1);
        next_cycle();
        MduStartE = 0; settle();                             // cycle 5
        check("mdu5_StallD", 32'(StallD), 32'h0);
        check("mdu5_Busy", 32'(MduBusy), 32'h1);
        check("mdu5_Count", 32'(StallCount), 32'd6);

        // memory wait with a load-use also present, cycles 6..8
        next_cycle(); idle();
        MemAccessM = 1; MemReadyM = 0; MemtoRegE = 1; rtE = 3; rsD = 3;
        settle();
        check("mem_StallM", 32'(StallM), 32'h1);
        check("mem_FlushW", 32'(FlushW), 32'h1);
        check("mem_FlushE", 32'(FlushE), 32'h0);
        next_cycle();
        next_cycle(); settle();                              // cycle 8
        check("mem_MduDone", 32'(MduDone), 32'h1);
        next_cycle(); idle(); settle();                      // cycle 9
        check("mem_Count", 32'(StallCount), 32'd9);
        check("mem_Busy", 32'(MduBusy), 32'h0);

        // reset in the middle of an MDU op
        next_cycle(); idle();
        MduStartE = 1; MduDstE = 7;
        next_cycle(); idle(); rsD = 7;
        next_cycle();                                        // counter at 3
        #1;
        check("rm_StallD_before", 32'(StallD), 32'h1);
        rst = 1'b1;
        #1;
        check("rm_Busy", 32'(MduBusy), 32'h0);
        check("rm_StallD", 32'(StallD), 32'h0);
        check("rm_Count", 32'(StallCount), 32'd0);
        rst = 1'b0;
        next_cycle(); settle();
        check("rm_StallD_after", 32'(StallD), 32'h0);

        // saturation of the stall counter
        next_cycle(); idle();
        MemtoRegE = 1; rtE = 3; rtD = 3;
        repeat (20) next_cycle();
        idle(); settle();
        check("sat_Count", 32'(StallCount), 32'd15);

        next_cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
